nms_window_buffer: RTL

Builds the 3x3 score neighbourhood for non-maximum suppression from the raster-order FAST score stream. Holds the two previous image rows of scores in line buffers and a 3x3 register window. For every pixel whose full neighbourhood lies inside the image, presents the centre score, the eight neighbour scores and the running address to the combinational NMS datapath directly downstream. Sits between the FAST score stage and the NMS datapath; one score accepted per valid cycle, no backpressure.

---
 rtl/nms_window_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/nms_window_buffer.sv
// 3x3 score neighbourhood builder for non-maximum suppression.
// Two row line buffers feed a 3x3 register window that drives the NMS datapath directly.
module nms_window_buffer #(
    parameter int WIDTH  = 180,
    parameter int HEIGHT = 180,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    input  logic [7:0]        inScore,
    output logic              outValid,
    output logic [7:0]        refScore,
    output logic [63:0]       adjScore,
    output logic [ADDR_W-1:0] refAddr,
    output logic              done
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

    state_t            state, stateNxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        lb1 [WIDTH];
    logic [7:0]        lb2 [WIDTH];
    logic [7:0]        lb1Rd, lb2Rd;
    logic [2:0][7:0]   newCol;
    logic [2:0][2:0][7:0] win;   // win[row][col]: row 0 = top, col 2 = newest (E)
    logic              colLast, lastPix;

    assign colLast = (col == COL_LAST);
    assign lastPix = colLast && (row == ROW_LAST);
    assign lb1Rd   = lb1[col];
    assign lb2Rd   = lb2[col];
    assign newCol  = {inScore, lb1Rd, lb2Rd};

    // Line buffers are never cleared; stale contents are masked by the validity rule.
    always_ff @(posedge clk) begin
        if (inValid) begin
            lb2[col] <= lb1[col];
            lb1[col] <= inScore;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            FILL:    if (inValid && colLast && row == ROW_ONE) stateNxt = RUN;
            RUN:     if (inValid && lastPix) stateNxt = DONE;
            DONE:    stateNxt = FILL;
            default: stateNxt = FILL;
        endcase
    end

    // Counters clear on the final sample so a sample arriving during DONE is pixel (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            cnt <= '0;
        end else if (inValid) begin
            if (lastPix) begin
                col <= '0;
                row <= '0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (colLast) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win <= '0;
        end else if (inValid) begin
            for (int r = 0; r < 3; r++)
                win[r] <= {newCol[r], win[r][2:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            done     <= 1'b0;
            refAddr  <= '0;
        end else begin
            outValid <= inValid && (state == RUN) && (col >= COL_TWO);
            done     <= inValid && lastPix;
            if (inValid) refAddr <= cnt + 1'b1;
        end
    end

    assign refScore = win[1][1];
    assign adjScore = {win[0][0], win[0][1], win[0][2],
                       win[1][0],            win[1][2],
                       win[2][0], win[2][1], win[2][2]};

endmodule
